// File: rtl/audio_voice_scheduler_pkg.sv
// Shared constants, clip table, FSM state type and output saturation for the
// voice scheduler.
package audio_pkg;

  localparam int NUM_VOICES = 4;
  localparam int SAMPLE_W   = 16;
  localparam int VIDX_W     = $clog2(NUM_VOICES);
  localparam int ACC_W      = SAMPLE_W + $clog2(NUM_VOICES);

  // Voice 0 is the looping background track; the rest are one-shot effects.
  localparam int unsigned CLIP_BASE [NUM_VOICES] = '{0, 88116, 88119, 88124};
  localparam int unsigned CLIP_LEN  [NUM_VOICES] = '{88116, 3, 5, 4};

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACCUM, OUTPUT} sched_state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
    if (a > SAT_MAX)      return SAMPLE_W'(SAT_MAX);
    else if (a < SAT_MIN) return SAMPLE_W'(SAT_MIN);
    else                  return SAMPLE_W'(a);
  endfunction

endpackage

// File: rtl/audio_voice_scheduler_if.sv
// Bundle of game-control, shared-ROM and codec signals around the scheduler.
interface audio_voice_scheduler_if #(
  parameter int NUM_VOICES = 4,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16
);
  logic                     sample_req;
  logic                     bg_enable;
  logic [NUM_VOICES-2:0]    sfx_trigger;
  logic [ADDR_W-1:0]        rom_addr;
  logic signed [DATA_W-1:0] rom_data;
  logic signed [DATA_W-1:0] audio_out;
  logic                     sample_valid;
  logic [NUM_VOICES-1:0]    voice_active;
  logic                     overrun;

  modport master (
    input  sample_req, bg_enable, sfx_trigger, rom_data,
    output rom_addr, audio_out, sample_valid, voice_active, overrun
  );

  modport slave (
    output sample_req, bg_enable, sfx_trigger, rom_data,
    input  rom_addr, audio_out, sample_valid, voice_active, overrun
  );
endinterface

// File: rtl/audio_voice_ctr.sv
// Per-voice clip position counter with active flag; looping voices follow an
// enable level, one-shot voices restart on a strobe and stop at clip end.
module audio_voice_ctr #(
  parameter int          ADDR_W = 17,
  parameter int unsigned LEN    = 4,
  parameter bit          LOOP   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctl,      // LOOP: play level; one-shot: restart strobe
  input  logic              advance,
  output logic [ADDR_W-1:0] pos,
  output logic              active
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LEN - 1);

  logic at_end;
  assign at_end = (pos == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos    <= '0;
      active <= 1'b0;
    end else if (LOOP) begin
      active <= ctl;
      if (advance) pos <= at_end ? '0 : pos + 1'b1;
    end else if (ctl) begin
      pos    <= '0;
      active <= 1'b1;
    end else if (advance) begin
      if (at_end) begin
        pos    <= '0;
        active <= 1'b0;
      end else begin
        pos <= pos + 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_voice_scheduler.sv
// Time-multiplexes one shared sample ROM between the clip voices and mixes one
// saturated sample per codec request.
module audio_voice_scheduler
  import audio_pkg::*;
#(
  parameter int          ADDR_W  = 17,
  parameter int          DATA_W  = SAMPLE_W,
  parameter int          ROM_LAT = 1,
  parameter int unsigned CLIP_BASE_TAB [NUM_VOICES] = CLIP_BASE,
  parameter int unsigned CLIP_LEN_TAB  [NUM_VOICES] = CLIP_LEN
) (
  input logic                     clk,
  input logic                     reset,
  audio_voice_scheduler_if.master bus
);

  localparam int WCNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  sched_state_t              state, state_nxt;
  logic [VIDX_W-1:0]         v, v_nxt;
  logic [WCNT_W-1:0]         wcnt, wcnt_nxt;
  logic signed [ACC_W-1:0]   acc, acc_nxt;
  logic [NUM_VOICES-2:0]     pending;
  logic [ADDR_W-1:0]         rom_addr_q, rom_addr_nxt;
  logic signed [DATA_W-1:0]  audio_out_q;
  logic                      sample_valid_q;
  logic                      overrun_q;
  logic [ADDR_W-1:0]         pos        [NUM_VOICES];
  logic [ADDR_W-1:0]         voice_addr [NUM_VOICES];
  logic [NUM_VOICES-1:0]     active, advance;
  logic                      frame_start, hit;
  logic [VIDX_W-1:0]         hit_v;
  int                        scan_from;

  assign frame_start      = (state == IDLE) && bus.sample_req;
  assign bus.rom_addr     = rom_addr_q;
  assign bus.audio_out    = audio_out_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.overrun      = overrun_q;
  assign bus.voice_active = active;

  // Triggers landing in the consuming cycle survive into the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            pending <= '0;
    else if (frame_start) pending <= bus.sfx_trigger;
    else                  pending <= pending | bus.sfx_trigger;
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    if (g == 0) begin : g_loop
      audio_voice_ctr #(.ADDR_W(ADDR_W), .LEN(CLIP_LEN_TAB[g]), .LOOP(1'b1)) u_ctr (
        .clk     (clk),
        .reset   (reset),
        .ctl     (bus.bg_enable),
        .advance (advance[g]),
        .pos     (pos[g]),
        .active  (active[g])
      );
    end else begin : g_shot
      audio_voice_ctr #(.ADDR_W(ADDR_W), .LEN(CLIP_LEN_TAB[g]), .LOOP(1'b0)) u_ctr (
        .clk     (clk),
        .reset   (reset),
        .ctl     (frame_start & pending[g-1]),
        .advance (advance[g]),
        .pos     (pos[g]),
        .active  (active[g])
      );
    end
    assign voice_addr[g] = ADDR_W'(CLIP_BASE_TAB[g]) + pos[g];
  end

  // Lowest active voice still to be visited; inactive voices cost no cycles.
  always_comb begin
    scan_from = (state == ISSUE) ? 0 : int'(v) + 1;
    hit       = 1'b0;
    hit_v     = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (active[i] && i >= scan_from) begin
        hit   = 1'b1;
        hit_v = VIDX_W'(i);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    v_nxt        = v;
    wcnt_nxt     = wcnt;
    acc_nxt      = acc;
    rom_addr_nxt = rom_addr_q;
    advance      = '0;
    case (state)
      IDLE: begin
        if (bus.sample_req) begin
          acc_nxt   = '0;
          v_nxt     = '0;
          state_nxt = ISSUE;
        end
      end
      ISSUE, ACCUM: begin
        if (state == ACCUM) begin
          acc_nxt    = acc + ACC_W'(bus.rom_data);
          advance[v] = 1'b1;
        end
        if (hit) begin
          v_nxt        = hit_v;
          rom_addr_nxt = voice_addr[hit_v];
          wcnt_nxt     = '0;
          state_nxt    = WAIT;
        end else begin
          state_nxt = OUTPUT;
        end
      end
      WAIT: begin
        if (wcnt == WCNT_W'(ROM_LAT - 1)) state_nxt = ACCUM;
        else                              wcnt_nxt  = wcnt + 1'b1;
      end
      OUTPUT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      v              <= '0;
      wcnt           <= '0;
      rom_addr_q     <= '0;
      audio_out_q    <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state          <= state_nxt;
      v              <= v_nxt;
      wcnt           <= wcnt_nxt;
      rom_addr_q     <= rom_addr_nxt;
      sample_valid_q <= (state == OUTPUT);
      if (state == OUTPUT) audio_out_q <= DATA_W'(saturate(acc));
      if (bus.sample_req && state != IDLE) overrun_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    acc <= acc_nxt;
  end

endmodule

// File: tb/tb_audio_voice_scheduler.sv
// Scoreboard bench for audio_voice_scheduler with a synchronous ROM model.
module tb_audio_voice_scheduler;

  localparam int unsigned TB_BASE [4] = '{0, 1000, 2000, 3000};
  localparam int unsigned TB_LEN  [4] = '{16, 3, 5, 4};

  typedef struct {
    int val;
    int lat;
    int start;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   rom_mode = 0;
  logic addr_moved = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;

  audio_voice_scheduler_if #(.NUM_VOICES(4), .ADDR_W(17), .DATA_W(16)) bus ();

  audio_voice_scheduler #(
    .ADDR_W(17), .DATA_W(16), .ROM_LAT(1),
    .CLIP_BASE_TAB(TB_BASE), .CLIP_LEN_TAB(TB_LEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic signed [15:0] rom_fn(input logic [16:0] a, input int mode);
    case (mode)
      0:       return 16'(a);
      1:       return (a < 17'd1000) ? 16'sd30000 : 16'sd10000;
      2:       return (a < 17'd1000) ? -16'sd30000 : -16'sd10000;
      default: return 16'sd1;
    endcase
  endfunction

  always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr, rom_mode);

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per sample_valid pulse.
  always @(negedge clk) begin
    if (bus.rom_addr != 17'd0) addr_moved = 1'b1;
    if (bus.sample_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_valid: audio_out %0d with no sample outstanding", bus.audio_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("audio_out", int'(bus.audio_out), mon_e.val);
        chk("latency", cyc - mon_e.start, mon_e.lat);
      end
    end
  end

  task automatic run_frame(input int e, input int lat, input logic [2:0] trig, input int dly);
    @(posedge clk); #1;
    bus.sample_req = 1'b1;
    if (dly == 0) bus.sfx_trigger = trig;
    exp_q.push_back('{e, lat, cyc + 1});
    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge clk); #1;
      bus.sample_req  = 1'b0;
      bus.sfx_trigger = (k == dly) ? trig : 3'b000;
    end
    @(posedge clk); #1;
    bus.sfx_trigger = 3'b000;
  endtask

  task automatic pulse_trig(input logic [2:0] trig);
    @(posedge clk); #1;
    bus.sfx_trigger = trig;
    @(posedge clk); #1;
    bus.sfx_trigger = 3'b000;
  endtask

  initial begin
    reset           = 1'b1;
    bus.sample_req  = 1'b0;
    bus.bg_enable   = 1'b0;
    bus.sfx_trigger = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_audio_out", int'(bus.audio_out), 0);
    chk("rst_sample_valid", int'(bus.sample_valid), 0);
    chk("rst_rom_addr", int'(bus.rom_addr), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    chk("rst_voice_active", int'(bus.voice_active), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // No active voices: silent frame, ROM address untouched.
    run_frame(0, 2, 3'b000, 0);
    chk("rom_addr_stays_0", int'(addr_moved), 0);

    // Background only, address-as-data, through the loop wrap.
    rom_mode      = 0;
    bus.bg_enable = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("bg_active", int'(bus.voice_active), 4'b0001);
    for (int i = 0; i < 16; i++) run_frame(i, 4, 3'b000, 0);
    chk("bg_active_at_wrap", int'(bus.voice_active[0]), 1);
    run_frame(0, 4, 3'b000, 0);
    chk("bg_active_after_wrap", int'(bus.voice_active), 4'b0001);

    // Saturation with background plus voice 1.
    rom_mode = 1;
    pulse_trig(3'b001);
    run_frame(32767, 6, 3'b000, 0);
    rom_mode = 2;
    run_frame(-32768, 6, 3'b000, 0);
    rom_mode = 3;
    run_frame(2, 6, 3'b000, 0);
    chk("v1_ended", int'(bus.voice_active), 4'b0001);

    // One-shot length, retrigger mid-play and retrigger on the last frame.
    rom_mode      = 0;
    bus.bg_enable = 1'b0;
    repeat (2) @(posedge clk); #1;
    pulse_trig(3'b001);
    chk("trig_pending_only", int'(bus.voice_active), 0);
    run_frame(1000, 4, 3'b000, 0);
    chk("v1_active", int'(bus.voice_active), 4'b0010);
    run_frame(1001, 4, 3'b001, 1);
    run_frame(1000, 4, 3'b000, 0);
    run_frame(1001, 4, 3'b000, 0);
    run_frame(1002, 4, 3'b001, 2);
    run_frame(1000, 4, 3'b000, 0);
    run_frame(1001, 4, 3'b000, 0);
    run_frame(1002, 4, 3'b000, 0);
    chk("v1_done", int'(bus.voice_active), 0);
    run_frame(0, 2, 3'b001, 0);
    run_frame(1000, 4, 3'b000, 0);
    run_frame(1001, 4, 3'b000, 0);
    run_frame(1002, 4, 3'b000, 0);

    // Four voices active, second request 3 cycles into the frame.
    rom_mode      = 3;
    bus.bg_enable = 1'b1;
    repeat (2) @(posedge clk); #1;
    pulse_trig(3'b111);
    @(posedge clk); #1;
    bus.sample_req = 1'b1;
    exp_q.push_back('{4, 10, cyc + 1});
    @(posedge clk); #1;
    bus.sample_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    bus.sample_req = 1'b1;
    @(posedge clk); #1;
    bus.sample_req = 1'b0;
    chk("overrun_set", int'(bus.overrun), 1);
    repeat (10) @(posedge clk); #1;
    chk("overrun_held", int'(bus.overrun), 1);
    run_frame(4, 10, 3'b000, 0);
    chk("overrun_sticky", int'(bus.overrun), 1);

    // Reset while the FSM sits in WAIT.
    @(posedge clk); #1;
    bus.sample_req = 1'b1;
    @(posedge clk); #1;
    bus.sample_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_audio_out", int'(bus.audio_out), 0);
    chk("midrst_sample_valid", int'(bus.sample_valid), 0);
    chk("midrst_rom_addr", int'(bus.rom_addr), 0);
    chk("midrst_overrun", int'(bus.overrun), 0);
    chk("midrst_voice_active", int'(bus.voice_active), 0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("post_rst_active", int'(bus.voice_active), 4'b0001);
    run_frame(1, 4, 3'b000, 0);

    repeat (3) @(posedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
